// File: rtl/glue_pkg.sv
// Shared definitions for the glue arbiter: state encoding, counter width,
// parameter defaults and the round-robin helper.
package glue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam int CNT_W   = 16;
  localparam int NUM_REQ = 4;

  localparam int HOLD_MIN_US_DEF = 10;
  localparam int HOLD_MAX_US_DEF = 1000;
  localparam int GUARD_US_DEF    = 2;

  // First requester found scanning upward from ptr+1, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] reqs, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && reqs[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/glue_sync.sv
// Two-flop synchronizer; with EDGE_EN set the output is instead a registered
// one-clk strobe marking a rising edge of the synchronized input.
module glue_sync #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  generate
    if (EDGE_EN) begin : g_edge
      logic r_prev;
      logic r_rise;

      // Strobe lands three clk after the input edge.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_prev <= 1'b0;
          r_rise <= 1'b0;
        end else begin
          r_prev <= r_sync;
          r_rise <= r_sync & ~r_prev;
        end
      end

      assign o_q = r_rise;
    end else begin : g_level
      assign o_q = r_sync;
    end
  endgenerate

endmodule

// File: rtl/glue_arbiter.sv
// Four-way round-robin arbiter with min/max hold time and a break-before-make
// guard gap, timed by a sampled 1 MHz timebase.
module glue_arbiter
  import glue_pkg::*;
#(
  parameter int HOLD_MIN_US = HOLD_MIN_US_DEF,
  parameter int HOLD_MAX_US = HOLD_MAX_US_DEF,
  parameter int GUARD_US    = GUARD_US_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1MHz,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HOLD_MIN_C = CNT_W'(HOLD_MIN_US);
  localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX_US);
  localparam logic [CNT_W-1:0] GUARD_C    = CNT_W'(GUARD_US);

  logic             w_tick;
  logic [3:0]       w_reqS;

  state_t           r_state;
  logic [3:0]       r_grant;
  logic [1:0]       r_grantId;
  logic             r_busy;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_holdCnt;
  logic [CNT_W-1:0] r_guardCnt;

  state_t           w_stateNxt;
  logic [3:0]       w_grantNxt;
  logic [1:0]       w_grantIdNxt;
  logic             w_busyNxt;
  logic [1:0]       w_ptrNxt;
  logic [CNT_W-1:0] w_holdNxt;
  logic [CNT_W-1:0] w_guardNxt;
  logic [1:0]       w_winner;
  logic [3:0]       w_ownMask;
  logic             w_dropExit;
  logic             w_maxExit;

  glue_sync #(.EDGE_EN(1'b1)) u_tick_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (clk_1MHz),
    .o_q     (w_tick)
  );

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_sync
      glue_sync #(.EDGE_EN(1'b0)) u_req_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (req[g]),
        .o_q     (w_reqS[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grantId  <= '0;
      r_busy     <= 1'b0;
      r_ptr      <= 2'd3;
      r_holdCnt  <= '0;
      r_guardCnt <= '0;
    end else begin
      r_state    <= w_stateNxt;
      r_grant    <= w_grantNxt;
      r_grantId  <= w_grantIdNxt;
      r_busy     <= w_busyNxt;
      r_ptr      <= w_ptrNxt;
      r_holdCnt  <= w_holdNxt;
      r_guardCnt <= w_guardNxt;
    end
  end

  // A drop and a max-hold revoke in the same clk both resolve to one GUARD entry.
  assign w_winner   = rr_pick(w_reqS, r_ptr);
  assign w_ownMask  = one_hot(r_ptr);
  assign w_dropExit = ~|(w_reqS & w_ownMask) && (r_holdCnt >= HOLD_MIN_C);
  assign w_maxExit  = (r_holdCnt >= HOLD_MAX_C) && |(w_reqS & ~w_ownMask);

  always_comb begin
    w_stateNxt   = r_state;
    w_grantNxt   = r_grant;
    w_grantIdNxt = r_grantId;
    w_ptrNxt     = r_ptr;
    w_holdNxt    = r_holdCnt;
    w_guardNxt   = r_guardCnt;

    case (r_state)
      IDLE: begin
        w_grantNxt = '0;
        if (|w_reqS) begin
          w_stateNxt   = GRANT;
          w_grantNxt   = one_hot(w_winner);
          w_grantIdNxt = w_winner;
          w_ptrNxt     = w_winner;
          w_holdNxt    = '0;
        end
      end

      GRANT: begin
        if (w_dropExit || w_maxExit) begin
          w_stateNxt = GUARD;
          w_grantNxt = '0;
          w_guardNxt = '0;
        end else if (w_tick && (r_holdCnt != '1)) begin
          w_holdNxt = r_holdCnt + 1'b1;
        end
      end

      GUARD: begin
        w_grantNxt = '0;
        // A zero-length guard still spends one clk here.
        if (GUARD_C == '0) begin
          w_stateNxt = IDLE;
        end else if (w_tick) begin
          if ((r_guardCnt + 1'b1) >= GUARD_C) begin
            w_stateNxt = IDLE;
          end else begin
            w_guardNxt = r_guardCnt + 1'b1;
          end
        end
      end

      default: begin
        w_stateNxt = IDLE;
        w_grantNxt = '0;
      end
    endcase

    w_busyNxt = (w_stateNxt == GRANT) || (w_stateNxt == GUARD);
  end

  assign grant    = r_grant;
  assign grant_id = r_grantId;
  assign busy     = r_busy;

endmodule

// File: tb/tb_glue_arbiter.sv
// Scoreboard bench for glue_arbiter: expected winners are queued as requests
// are driven and popped whenever a new grant appears.
module tb_glue_arbiter;

  logic       clk;
  logic       reset;
  logic       clk_1MHz;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int benchTick  = 0;
  int riseTick   = 0;
  int fallTick   = 0;
  int lastDur    = 0;
  int lastGap    = 0;
  int grantCount = 0;
  int fallCount  = 0;
  logic [3:0] prevGrant = '0;
  logic [1:0] expQ[$];

  glue_arbiter #(
    .HOLD_MIN_US (10),
    .HOLD_MAX_US (1000),
    .GUARD_US    (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_1MHz (clk_1MHz),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Compressed timebase: one tick every 6 clk, edges kept off the clk edges.
  initial begin
    clk_1MHz = 1'b0;
    #5;
    forever #60 clk_1MHz = ~clk_1MHz;
  end

  always @(posedge clk_1MHz) benchTick++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int clampI(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  always @(negedge clk) begin
    logic [1:0] e;
    if (grant != prevGrant) begin
      checkOutput("onehot0", 32'($onehot0(grant)), 1);
      checkOutput("break_before_make", 32'((prevGrant == 4'b0) || (grant == 4'b0)), 1);
      if (grant != 4'b0) begin
        lastGap  = benchTick - fallTick;
        riseTick = benchTick;
        grantCount++;
        if (expQ.size() == 0) begin
          checkOutput("sb_unexpected_grant", 32'(grant), 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_grant", 32'(grant), 32'(4'b0001 << e));
          checkOutput("sb_grant_id", 32'(grant_id), 32'(e));
          checkOutput("sb_busy", 32'(busy), 1);
        end
      end else begin
        fallTick = benchTick;
        lastDur  = benchTick - riseTick;
        fallCount++;
      end
      prevGrant = grant;
    end
  end

  task automatic syncNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic waitTicks(input int n);
    repeat (n) @(posedge clk_1MHz);
    syncNeg();
  endtask

  task automatic waitGrants(input int n, input int budget);
    int c = 0;
    while (grantCount < n && c < budget) begin
      syncNeg();
      c++;
    end
    if (grantCount < n) checkOutput("timeout_grant", grantCount, n);
  endtask

  task automatic waitFalls(input int n, input int budget);
    int c = 0;
    while (fallCount < n && c < budget) begin
      syncNeg();
      c++;
    end
    if (fallCount < n) checkOutput("timeout_release", fallCount, n);
  endtask

  task automatic waitIdle(input int budget);
    int c = 0;
    while ((busy !== 1'b0 || grant !== 4'b0) && c < budget) begin
      syncNeg();
      c++;
    end
    checkOutput("idle_busy", 32'(busy), 0);
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic applyReset();
    syncNeg();
    reset = 1'b1;
    repeat (3) syncNeg();
    reset = 1'b0;
    syncNeg();
  endtask

  initial begin
    int lat;
    int g0;
    int f0;
    reset = 1'b1;
    req   = '0;
    $display("[TB] start");

    // Reset state and quiet release.
    repeat (3) syncNeg();
    checkOutput("reset_grant", 32'(grant), 0);
    checkOutput("reset_grant_id", 32'(grant_id), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (6) syncNeg();
    checkOutput("post_reset_grant", 32'(grant), 0);

    // Single requester 0.
    expQ.push_back(2'd0);
    applyStimulus(4'b0001);
    lat = 0;
    while (grant == 4'b0 && lat < 20) begin
      syncNeg();
      lat++;
    end
    checkOutput("s1_latency", lat, clampI(lat, 1, 3));
    waitTicks(30);
    applyStimulus(4'b0000);
    waitIdle(200);
    checkOutput("s1_hold", lastDur, clampI(lastDur, 30, 31));

    // All four at once: round-robin order 0..3, 20 ticks each.
    applyReset();
    g0 = grantCount;
    f0 = fallCount;
    for (int k = 0; k < 4; k++) expQ.push_back(2'(k));
    applyStimulus(4'b1111);
    for (int k = 0; k < 4; k++) begin
      waitGrants(g0 + k + 1, 200);
      if (k > 0) checkOutput("s2_gap", lastGap, clampI(lastGap, 1, 3));
      waitTicks(20);
      req[k] = 1'b0;
      waitFalls(f0 + k + 1, 200);
      checkOutput("s2_hold", lastDur, clampI(lastDur, 20, 21));
    end
    waitIdle(200);

    // Short pulse on requester 1 still gets the minimum hold.
    expQ.push_back(2'd1);
    g0 = grantCount;
    applyStimulus(4'b0010);
    waitGrants(g0 + 1, 50);
    waitTicks(3);
    applyStimulus(4'b0000);
    waitIdle(200);
    checkOutput("s3_min_hold", lastDur, clampI(lastDur, 9, 11));
    checkOutput("s3_last_id", 32'(grant_id), 1);

    // Requester 2 held forever gets revoked at max hold once 0 is waiting.
    expQ.push_back(2'd2);
    expQ.push_back(2'd0);
    g0 = grantCount;
    applyStimulus(4'b0100);
    waitGrants(g0 + 1, 50);
    waitTicks(50);
    applyStimulus(4'b0101);
    waitGrants(g0 + 2, 8000);
    checkOutput("s4_max_hold", lastDur, clampI(lastDur, 999, 1001));
    checkOutput("s4_gap", lastGap, clampI(lastGap, 1, 3));
    applyStimulus(4'b0001);
    waitTicks(15);
    applyStimulus(4'b0000);
    waitIdle(200);

    // Lone requester 3 is never revoked, far past max hold.
    expQ.push_back(2'd3);
    g0 = grantCount;
    applyStimulus(4'b1000);
    waitGrants(g0 + 1, 50);
    f0 = fallCount;
    waitTicks(5000);
    checkOutput("s5_still_granted", 32'(grant), 32'(4'b1000));
    checkOutput("s5_no_revoke", fallCount, f0);
    applyStimulus(4'b0000);
    waitIdle(200);

    // Reset mid-grant drops at once; afterwards requester 0 wins first.
    expQ.push_back(2'd2);
    g0 = grantCount;
    applyStimulus(4'b0100);
    waitGrants(g0 + 1, 50);
    waitTicks(5);
    reset = 1'b1;
    syncNeg();
    checkOutput("s6_reset_grant", 32'(grant), 0);
    checkOutput("s6_reset_busy", 32'(busy), 0);
    checkOutput("s6_reset_id", 32'(grant_id), 0);
    expQ.push_back(2'd0);
    expQ.push_back(2'd2);
    g0 = grantCount;
    applyStimulus(4'b0101);
    repeat (2) syncNeg();
    reset = 1'b0;
    waitGrants(g0 + 1, 50);
    waitTicks(15);
    applyStimulus(4'b0100);
    waitGrants(g0 + 2, 200);
    waitTicks(15);
    applyStimulus(4'b0000);
    waitIdle(200);

    checkOutput("sb_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
